dbus_router: RTL and testbench
==============================

DBUS_ROUTER -- requirements
Module: dbus_router

Interface
REQ-001 Parameter NCH, default 4, number of peripheral channels (legal 1..8).
REQ-002 Parameter BASE_LIST, default {8'h13,8'h12,8'h11,8'h10}, NCH x 8-bit region bases (channel k at bits [8k+7:8k]) compared against m_addr[31:24].
REQ-003 Parameter TIMEOUT_CYC, default 255, maximum wait cycles before forced termination (legal 2..65535).
REQ-004 Parameter ERR_DATA, default 32'hDEADBEEF, read data returned on error.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 cpurst_n  in  1  asynchronous active-low reset.
REQ-007 m_cs / m_we  in  1 / 1  master access request / write qualifier.
REQ-008 m_addr / m_wdata  in  32 / 32  master byte address / write data.
REQ-009 m_ben  in  4  master byte enables.
REQ-010 m_stall  out  1  master must hold request stable while high.
REQ-011 m_rdata / m_rvalid  out  32 / 1  registered read data / valid pulse.
REQ-012 bus_err / err_addr  out  1 / 32  one-cycle error pulse / address of last errored access.
REQ-013 s_req / s_we  out  NCH / 1  per-channel request (one-hot or zero) / shared write qualifier.
REQ-014 s_addr / s_wdata / s_ben  out  32 / 32 / 4  shared: {8'b0, m_addr[23:0]}, m_wdata, m_ben.
REQ-015 s_rdata / s_ack  in  NCH x 32 / NCH  per-channel read data (channel k at [32k+31:32k]) / per-channel completion.

Function
REQ-016 Decode is combinational: hit[k] = m_cs & (m_addr[31:24] == BASE k); overlapping bases resolve to lowest index; s_req is one-hot of the winner.
REQ-017 s_req, s_we, s_addr, s_wdata, s_ben are combinational from master inputs; no added request latency.
REQ-018 m_stall = m_cs & hit & !s_ack[sel] in IDLE/WAIT, forced 0 on the timeout-termination cycle.
REQ-019 s_ack on a non-selected channel is ignored.
REQ-020 Access completes on the cycle s_ack[sel] is high while s_req[sel] is high (zero-wait if ack arrives on the first cycle).
REQ-021 Read completion: s_rdata[sel] captured; m_rdata updated and m_rvalid high for exactly one cycle on the next edge.
REQ-022 Write completion: no m_rvalid; m_rdata holds.
REQ-023 FSM states IDLE, WAIT. IDLE->WAIT on hit without ack; WAIT->IDLE on ack, timeout, or m_cs dropping (abort, no response).
REQ-024 Wait counter (16 bit) clears in IDLE, increments each WAIT cycle; when counter == TIMEOUT_CYC-1 without ack, access terminates: m_stall 0 that cycle, FSM returns to IDLE.
REQ-025 Timeout termination: next edge bus_err pulses one cycle, err_addr <= m_addr; reads additionally give m_rdata=ERR_DATA with m_rvalid pulse.
REQ-026 Unmapped access (m_cs with no hit): no s_req, no stall; next edge bus_err pulse, err_addr <= m_addr, reads return ERR_DATA with m_rvalid.
REQ-027 Back-to-back accesses supported: new request accepted in IDLE the cycle after a completion; m_rvalid of prior read may coincide.
REQ-028 Ack and timeout in the same cycle: ack wins, no error.

Reset
REQ-029 On cpurst_n low, immediately: FSM=IDLE, counter=0, m_rvalid=0, bus_err=0, m_rdata=0, err_addr=0.
REQ-030 Reset mid-WAIT discards the access with no response or error; combinational s_req follows m_cs as normal after release.

Configuration
REQ-031 Macro DBUS_ROUTER_TIMEOUT_EN: defined -> REQ-024/025 active; undefined -> no counter, WAIT persists until ack or m_cs drop, bus_err only from unmapped access.

Verification
REQ-032 Read ch1 (m_addr=32'h1100_0010), s_ack[1] on 3rd cycle, s_rdata=32'hA5A5_0001 -> m_stall high 2 cycles, s_addr=32'h0000_0010, m_rvalid pulse with m_rdata=32'hA5A5_0001 next cycle.
REQ-033 Write ch0 with same-cycle ack -> zero stall, s_req=4'b0001, no m_rvalid.
REQ-034 Read 32'h2000_0000 (unmapped) -> no stall, next cycle bus_err=1, err_addr=32'h2000_0000, m_rdata=32'hDEADBEEF, m_rvalid=1.
REQ-035 TIMEOUT_EN, TIMEOUT_CYC=4, read ch3 never acked -> stall 3 cycles, released 4th, then bus_err and m_rdata=ERR_DATA; without macro stall persists 100 cycles.
REQ-036 Ack on ch2 while ch1 selected -> ignored, stall continues; ack and timeout same cycle -> normal completion, no bus_err.
REQ-037 cpurst_n low during WAIT -> all outputs reset asynchronously, no m_rvalid after release.

Source files
------------

// File: rtl/dbus_router.sv
// dbus_router: single-master to NCH-channel data bus router.
// Decodes m_addr[31:24] against per-channel bases. The request path is combinational.
// The response path (m_rdata/m_rvalid/bus_err/err_addr) is registered.
// Optional feature macro: DBUS_ROUTER_TIMEOUT_EN.
//   - Defined: a stalled access is forcibly terminated with an error after TIMEOUT_CYC cycles.
//   - Undefined: a stalled access waits until it is acked or until m_cs drops.
module dbus_router #(
    parameter int              NCH         = 4,
    parameter logic [NCH*8-1:0] BASE_LIST  = {8'h13, 8'h12, 8'h11, 8'h10},
    parameter int              TIMEOUT_CYC = 255,
    parameter logic [31:0]     ERR_DATA    = 32'hDEADBEEF
) (
    input  logic              clk,
    input  logic              cpurst_n,
    input  logic              m_cs,
    input  logic              m_we,
    input  logic [31:0]       m_addr,
    input  logic [31:0]       m_wdata,
    input  logic [3:0]        m_ben,
    output logic              m_stall,
    output logic [31:0]       m_rdata,
    output logic              m_rvalid,
    output logic              bus_err,
    output logic [31:0]       err_addr,
    output logic [NCH-1:0]    s_req,
    output logic              s_we,
    output logic [31:0]       s_addr,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_ben,
    input  logic [NCH*32-1:0] s_rdata,
    input  logic [NCH-1:0]    s_ack
);

    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [NCH-1:0]   w_match;
    logic             w_hit;
    logic [SELW-1:0]  w_sel;
    logic             w_ack_sel;
    logic [31:0]      w_rdata_sel;
    logic             w_access;
    logic             w_unmapped;
    logic             w_done;
    logic             w_expire;
    logic             w_cnt_full;
    logic             w_stall;
    logic             r_rvalid;
    logic             r_err;
    logic [31:0]      r_rdata;
    logic [31:0]      r_err_addr;

    // Region decode: the lowest-indexed matching base wins when bases overlap.
    always_comb begin
        w_match = '0;
        w_sel   = '0;
        for (int k = 0; k < NCH; k++) begin
            w_match[k] = (m_addr[31:24] == BASE_LIST[8*k +: 8]);
        end
        for (int k = NCH - 1; k >= 0; k--) begin
            w_sel = w_match[k] ? SELW'(k) : w_sel;
        end
        w_hit = |w_match;
    end

    assign w_ack_sel   = s_ack[w_sel];
    assign w_rdata_sel = s_rdata[32*w_sel +: 32];
    assign w_access    = m_cs & w_hit;
    assign w_unmapped  = m_cs & ~w_hit;
    assign w_done      = w_access & w_ack_sel;

`ifdef DBUS_ROUTER_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_nxt;

    // Counts the cycles the current access has been stalled, including its first cycle.
    always_comb begin
        w_wait_cnt_nxt = 16'd0;
        if (w_stall) begin
            w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end else begin
            w_wait_cnt_nxt = 16'd0;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_wait_cnt <= 16'd0;
        end else begin
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    assign w_cnt_full = (r_state == ST_WAIT) && (r_wait_cnt == 16'(TIMEOUT_CYC - 1));
`else
    assign w_cnt_full = 1'b0;
`endif

    // An ack always beats the timeout; the terminating cycle releases the stall.
    assign w_expire = w_access & ~w_ack_sel & w_cnt_full;
    assign w_stall  = w_access & ~w_ack_sel & ~w_cnt_full;

    // Next-state logic: stay in WAIT only while the access is still being stalled.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_stall) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_stall) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Master response: read data, read-valid pulse and error pulse with the faulting address.
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_rvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
            r_err_addr <= 32'd0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            if (w_done) begin
                if (!m_we) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_rdata_sel;
                end
            end else if (w_unmapped || w_expire) begin
                r_err      <= 1'b1;
                r_err_addr <= m_addr;
                if (!m_we) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= ERR_DATA;
                end
            end
        end
    end

    assign m_stall  = w_stall;
    assign m_rvalid = r_rvalid;
    assign m_rdata  = r_rdata;
    assign bus_err  = r_err;
    assign err_addr = r_err_addr;

    assign s_req   = w_access ? (NCH'(1) << w_sel) : '0;
    assign s_we    = m_we;
    assign s_addr  = {8'h00, m_addr[23:0]};
    assign s_wdata = m_wdata;
    assign s_ben   = m_ben;

endmodule

// File: tb/tb_dbus_router.sv
// tb_dbus_router: directed stimulus against a spec-level model of dbus_router.
// The model tracks how many cycles the current access has been stalled.
// TIMEOUT_CYC is 4, so timeout behaviour is exercised when DBUS_ROUTER_TIMEOUT_EN is defined.
module tb_dbus_router;

    localparam int          NCH = 4;
    localparam int          TMO = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;
`ifdef DBUS_ROUTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        cpurst_n;
    logic        m_cs;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_ben;
    logic        m_stall;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        bus_err;
    logic [31:0] err_addr;
    logic [3:0]  s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_ben;
    logic [127:0] s_rdata;
    logic [3:0]  s_ack;
    logic [31:0] ch_rdata [4];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state.
    logic        mdl_rvalid;
    logic        mdl_err;
    logic [31:0] mdl_rdata;
    logic [31:0] mdl_err_addr;
    int          mdl_age;

    assign s_rdata = {ch_rdata[3], ch_rdata[2], ch_rdata[1], ch_rdata[0]};

    dbus_router #(.NCH(4), .BASE_LIST({8'h13, 8'h12, 8'h11, 8'h10}),
                  .TIMEOUT_CYC(TMO), .ERR_DATA(ERR)) dut (
        .clk(clk), .cpurst_n(cpurst_n), .m_cs(m_cs), .m_we(m_we),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ben(m_ben), .m_stall(m_stall),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .bus_err(bus_err), .err_addr(err_addr),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ben(s_ben), .s_rdata(s_rdata), .s_ack(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Region owner: the lowest channel whose base equals the top address byte, or -1 if none.
    function automatic int mdl_win(input logic [31:0] a);
        logic [7:0] bases [4];
        bases = '{8'h10, 8'h11, 8'h12, 8'h13};
        for (int k = 0; k < NCH; k++) begin
            if (a[31:24] == bases[k]) return k;
        end
        return -1;
    endfunction

    function automatic bit mdl_acked(input logic [31:0] a, input logic [3:0] ack);
        int w;
        w = mdl_win(a);
        return (w >= 0) ? ack[w] : 1'b0;
    endfunction

    // Termination is due once the access has already been stalled TMO-1 cycles.
    function automatic bit mdl_tmo(input int age);
        return TO_EN && (age == TMO - 1);
    endfunction

    // Model: registered master response plus the stalled-cycle age of the current access.
    always @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            mdl_rvalid   <= 1'b0;
            mdl_err      <= 1'b0;
            mdl_rdata    <= 32'd0;
            mdl_err_addr <= 32'd0;
            mdl_age      <= 0;
        end else begin
            mdl_rvalid <= 1'b0;
            mdl_err    <= 1'b0;
            if (m_cs && mdl_win(m_addr) < 0) begin
                mdl_err      <= 1'b1;
                mdl_err_addr <= m_addr;
                if (!m_we) begin
                    mdl_rvalid <= 1'b1;
                    mdl_rdata  <= ERR;
                end
            end else if (m_cs && mdl_acked(m_addr, s_ack)) begin
                if (!m_we) begin
                    mdl_rvalid <= 1'b1;
                    mdl_rdata  <= ch_rdata[mdl_win(m_addr)];
                end
            end else if (m_cs && mdl_tmo(mdl_age)) begin
                mdl_err      <= 1'b1;
                mdl_err_addr <= m_addr;
                if (!m_we) begin
                    mdl_rvalid <= 1'b1;
                    mdl_rdata  <= ERR;
                end
            end
            if (m_cs && mdl_win(m_addr) >= 0 && !mdl_acked(m_addr, s_ack) && !mdl_tmo(mdl_age))
                mdl_age <= mdl_age + 1;
            else
                mdl_age <= 0;
        end
    end

    // Compare process: every output, every cycle, against the model.
    always @(negedge clk) begin
        int          w;
        logic [3:0]  er;
        logic        es;
        w  = mdl_win(m_addr);
        er = (m_cs && w >= 0) ? (4'b0001 << w) : 4'b0000;
        es = m_cs && (w >= 0) && !mdl_acked(m_addr, s_ack) && !mdl_tmo(mdl_age);
        check("cmp_s_req",    {28'd0, s_req},    {28'd0, er});
        check("cmp_m_stall",  {31'd0, m_stall},  {31'd0, es});
        check("cmp_s_addr",   s_addr,            {8'h00, m_addr[23:0]});
        check("cmp_s_wdata",  s_wdata,           m_wdata);
        check("cmp_s_ben_we", {27'd0, s_we, s_ben}, {27'd0, m_we, m_ben});
        check("cmp_m_rvalid", {31'd0, m_rvalid}, {31'd0, mdl_rvalid});
        check("cmp_bus_err",  {31'd0, bus_err},  {31'd0, mdl_err});
        check("cmp_err_addr", err_addr,          mdl_err_addr);
        if (mdl_rvalid) check("cmp_m_rdata", m_rdata, mdl_rdata);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cs, input logic we, input logic [31:0] a, input logic [3:0] ack);
        m_cs   = cs;
        m_we   = we;
        m_addr = a;
        s_ack  = ack;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cpurst_n = 1'b0;
        m_cs = 1'b0; m_we = 1'b0; m_addr = 32'd0; m_wdata = 32'h0BAD_F00D; m_ben = 4'hF;
        s_ack = 4'b0000;
        for (int k = 0; k < 4; k++) ch_rdata[k] = 32'h0;
        repeat (3) cyc();
        check("rst_m_rvalid", {31'd0, m_rvalid}, 32'd0);
        check("rst_bus_err",  {31'd0, bus_err},  32'd0);
        check("rst_m_rdata",  m_rdata,           32'd0);
        check("rst_err_addr", err_addr,          32'd0);
        cpurst_n = 1'b1;
        cyc();

        // Read ch1, ack on the third cycle.
        ch_rdata[1] = 32'hA5A5_0001;
        drive(1'b1, 1'b0, 32'h1100_0010, 4'b0000);
        @(negedge clk);
        check("r1_stall_c1", {31'd0, m_stall}, 32'd1);
        check("r1_s_addr",   s_addr, 32'h0000_0010);
        check("r1_s_req",    {28'd0, s_req}, 32'h2);
        cyc();
        @(negedge clk);
        check("r1_stall_c2", {31'd0, m_stall}, 32'd1);
        cyc();
        s_ack = 4'b0010;
        @(negedge clk);
        check("r1_stall_c3", {31'd0, m_stall}, 32'd0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 4'b0000);
        check("r1_rvalid", {31'd0, m_rvalid}, 32'd1);
        check("r1_rdata",  m_rdata, 32'hA5A5_0001);
        cyc();
        check("r1_rvalid_end", {31'd0, m_rvalid}, 32'd0);

        // Write ch0 with same-cycle ack.
        m_wdata = 32'h1234_ABCD; m_ben = 4'b0101;
        drive(1'b1, 1'b1, 32'h1000_0004, 4'b0001);
        @(negedge clk);
        check("w0_stall", {31'd0, m_stall}, 32'd0);
        check("w0_s_req", {28'd0, s_req}, 32'h1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 4'b0000);
        check("w0_rvalid", {31'd0, m_rvalid}, 32'd0);
        check("w0_rdata_hold", m_rdata, 32'hA5A5_0001);
        cyc();

        // Unmapped read.
        drive(1'b1, 1'b0, 32'h2000_0000, 4'b0000);
        @(negedge clk);
        check("um_stall", {31'd0, m_stall}, 32'd0);
        check("um_s_req", {28'd0, s_req}, 32'h0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 4'b0000);
        check("um_bus_err",  {31'd0, bus_err}, 32'd1);
        check("um_err_addr", err_addr, 32'h2000_0000);
        check("um_rdata",    m_rdata, 32'hDEADBEEF);
        check("um_rvalid",   {31'd0, m_rvalid}, 32'd1);
        cyc();
        check("um_err_end", {31'd0, bus_err}, 32'd0);

        // Read ch3, never acked.
        drive(1'b1, 1'b0, 32'h1300_0020, 4'b0000);
        if (TO_EN) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                check("to_stall_held", {31'd0, m_stall}, 32'd1);
                cyc();
            end
            @(negedge clk);
            check("to_stall_rel", {31'd0, m_stall}, 32'd0);
            cyc();
            drive(1'b0, 1'b0, 32'h0, 4'b0000);
            check("to_bus_err",  {31'd0, bus_err}, 32'd1);
            check("to_err_addr", err_addr, 32'h1300_0020);
            check("to_rdata",    m_rdata, 32'hDEADBEEF);
            check("to_rvalid",   {31'd0, m_rvalid}, 32'd1);
        end else begin
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                check("nto_stall_held", {31'd0, m_stall}, 32'd1);
                cyc();
            end
            drive(1'b0, 1'b0, 32'h0, 4'b0000);
            cyc();
            check("nto_abort_err",    {31'd0, bus_err}, 32'd0);
            check("nto_abort_rvalid", {31'd0, m_rvalid}, 32'd0);
        end
        cyc();

        // Ack on a non-selected channel is ignored; then ch1 acks in the timeout cycle.
        ch_rdata[1] = 32'h1234_5678;
        ch_rdata[2] = 32'hFFFF_0000;
        drive(1'b1, 1'b0, 32'h1100_0040, 4'b0100);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("ign_stall", {31'd0, m_stall}, 32'd1);
            cyc();
        end
        s_ack = 4'b0010;
        @(negedge clk);
        check("ackto_stall", {31'd0, m_stall}, 32'd0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 4'b0000);
        check("ackto_bus_err", {31'd0, bus_err}, 32'd0);
        check("ackto_rvalid",  {31'd0, m_rvalid}, 32'd1);
        check("ackto_rdata",   m_rdata, 32'h1234_5678);
        cyc();

        // Back-to-back zero-wait reads on ch0 then ch2.
        ch_rdata[0] = 32'h0000_00C0;
        ch_rdata[2] = 32'h0000_00C2;
        drive(1'b1, 1'b0, 32'h1000_0000, 4'b0001);
        cyc();
        drive(1'b1, 1'b0, 32'h1200_0000, 4'b0100);
        check("b2b_rdata0", m_rdata, 32'h0000_00C0);
        @(negedge clk);
        check("b2b_s_req2", {28'd0, s_req}, 32'h4);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 4'b0000);
        check("b2b_rdata2",  m_rdata, 32'h0000_00C2);
        check("b2b_rvalid2", {31'd0, m_rvalid}, 32'd1);
        cyc();

        // Reset in the middle of a WAIT.
        drive(1'b1, 1'b0, 32'h1200_0008, 4'b0000);
        cyc();
        cyc();
        #2;
        cpurst_n = 1'b0;
        #1;
        check("rw_m_rdata",  m_rdata, 32'd0);
        check("rw_err_addr", err_addr, 32'd0);
        check("rw_rvalid",   {31'd0, m_rvalid}, 32'd0);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 4'b0000);
        cyc();
        cpurst_n = 1'b1;
        cyc();
        check("rw_post_rvalid", {31'd0, m_rvalid}, 32'd0);
        check("rw_post_err",    {31'd0, bus_err}, 32'd0);
        drive(1'b1, 1'b0, 32'h1000_0000, 4'b0000);
        @(negedge clk);
        check("rw_post_req", {28'd0, s_req}, 32'h1);
        cyc();
        drive(1'b0, 1'b0, 32'h0, 4'b0000);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
